// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx_i, oversamples each bit at mid-point, deserializes LSB-first
// Latency: rx_valid_o rises 1 clk after the sample tick of the last stop bit
// Backpressure: one holding register; a frame completing while it is full is dropped and overrun_o set
//
// Ports:
//   clk_i, reset_i (async, active-high)   clock / reset
//   rx_i                                  serial line, idle high, asynchronous to clk_i
//   baud_div_i                            clk cycles per sample tick (0 behaves as 1)
//   parity_en_i, parity_odd_i, stop2_i    frame format, captured when the start bit is confirmed
//   rx_data_o, parity_err_o, frame_err_o  received word and its error flags, qualified by rx_valid_o
//   rx_valid_o / rx_ready_i               valid/ready handshake towards the consumer
//   overrun_o                             sticky dropped-frame flag, cleared by the next handshake
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rx_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_WIDTH-1:0]  tick_cnt_q, tick_cnt_d, div_q, div_d;
  logic                  tick;
  state_t                state_q, state_d;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;
  logic                  sample_pt, fall, done;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, perr_out_q, perr_out_d;
  logic                  ferr_out_q, ferr_out_d, overrun_q, overrun_d;
  logic                  hs, load, drop;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // Free-running tick divider. The divisor is captured on each wrap so that a
  // baud_div_i change never truncates or stretches the period in progress.
  always_comb begin
    tick       = (tick_cnt_q >= div_q - DIV_WIDTH'(1));
    tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
    div_d      = div_q;
    if (tick) begin
      tick_cnt_d = '0;
      div_d      = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_cnt_q <= '0;
      div_q      <= DIV_WIDTH'(1);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
    end
  end

  // Frame FSM. START samples at half a bit; afterwards the oversample counter
  // restarts at each sample so every later sample lands a full bit later.
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;
    sample_pt  = tick && (os_cnt_q == ((state_q == S_START) ? OS_MID : OS_LAST));
    if (tick) os_cnt_d = sample_pt ? '0 : os_cnt_q + OSW'(1);

    case (state_q)
      S_IDLE: begin
        os_cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (sample_pt) begin
          if (!rx_sync_q) begin
            state_d    = S_DATA;
            par_en_d   = parity_en_i;
            par_odd_d  = parity_odd_i;
            stop2_d    = stop2_i;
            bit_cnt_d  = '0;
            stop_idx_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample_pt) begin
          shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BC_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
          else                      bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_PARITY: begin
        if (sample_pt) begin
          perr_d  = ((^shift_q) ^ rx_sync_q) != par_odd_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_pt) begin
          ferr_d = ferr_q | ~rx_sync_q;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ferr_d ? S_WAIT_HIGH : S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A break holds the line low; wait for it to end so it yields one frame.
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register. A completion may refill it in the same cycle it is drained.
  always_comb begin
    hs         = rx_valid_q & rx_ready_i;
    load       = done & (~rx_valid_q | rx_ready_i);
    drop       = done & rx_valid_q & ~rx_ready_i;
    rx_data_d  = load ? shift_q : rx_data_q;
    perr_out_d = load ? perr_d  : perr_out_q;
    ferr_out_d = load ? ferr_d  : ferr_out_q;
    rx_valid_d = load ? 1'b1 : (hs ? 1'b0 : rx_valid_q);
    overrun_d  = drop ? 1'b1 : (hs ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign overrun_o    = overrun_q;

endmodule
